// File: rtl/bus_pkg.sv
// Shared types and defaults for the bus grant watchdog and its ready-timeout counter.
package bus_pkg;

    // Arbiter states: a granted transaction always passes through RELEASE or ABORT
    // before the bus returns to IDLE, which gives the 2-cycle minimum gap between grants.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2,
        ABORT   = 2'd3
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT     = 100;
    localparam int DEFAULT_NUM_MASTERS = 2;

    // Counter width that can hold every value up to and including the timeout.
    function automatic int wd_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/ready_watchdog.sv
// Ready-timeout counter: counts consecutive cycles without slave ready while enabled
// and flags the cycle in which the limit is reached.
module ready_watchdog
    import bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rstN,
    input  logic enable,
    input  logic ready,
    output logic expire
);

    localparam int            CW   = wd_width(TIMEOUT);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: held at zero while disabled, restarted by any ready cycle,
    // otherwise incremented and saturated at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable || ready) begin
            cnt_d = '0;
        end else if (cnt_q != TERM) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A ready in the terminal cycle rescues the transaction, so it masks expiry.
    assign expire = enable && !ready && (cnt_q == TERM);

endmodule

// File: rtl/bus_grant_watchdog.sv
// Round-robin bus access controller with a per-transaction slave-ready watchdog.
// One slave port is shared between NUM_MASTERS requesters; a transaction that sees no
// slave ready for TIMEOUT cycles is aborted and the offending master gets a sticky error.
module bus_grant_watchdog
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic [NUM_MASTERS-1:0]         done,
    input  logic                           slave_ready,
    input  logic [NUM_MASTERS-1:0]         err_clr,
    output logic [NUM_MASTERS-1:0]         grant,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
    output logic                           busy,
    output logic                           abort,
    output logic [NUM_MASTERS-1:0]         err
);

    localparam int IDW = $clog2(NUM_MASTERS);

    // First requester strictly after ptr, wrapping; ptr itself has lowest priority.
    // Walking from farthest to nearest lets the nearest hit overwrite the others.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] r,
                                               input logic [IDW-1:0]         ptr);
        logic [IDW-1:0] pick;
        int             idx;
        pick = ptr;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NUM_MASTERS;
            if (r[idx]) begin
                pick = IDW'(idx);
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_MASTERS-1:0] to_onehot(input logic [IDW-1:0] id);
        logic [NUM_MASTERS-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    arb_state_t             state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [IDW-1:0]         grant_id_q;
    logic [IDW-1:0]         rr_ptr_q;
    logic                   busy_q;
    logic                   abort_q;
    logic [NUM_MASTERS-1:0] err_q;
    logic [NUM_MASTERS-1:0] err_d;

    logic                   wd_en;
    logic                   wd_expire;
    logic [IDW-1:0]         sel;
    logic                   any_req;
    logic                   xfer_end;
    logic                   timeout_hit;
    logic [NUM_MASTERS-1:0] err_set;

    // The watchdog only runs while a master owns the bus; IDLE clears it so
    // every grant starts from zero.
    assign wd_en = (state_q == GRANT);

    ready_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk     (clk),
        .rstN    (rstN),
        .enable  (wd_en),
        .ready   (slave_ready),
        .expire  (wd_expire)
    );

    // Arbitration pick and transaction exit decode. Only the granted master's
    // done/req matter; a completing transaction takes priority over a timeout.
    always_comb begin
        sel         = rr_pick(req, rr_ptr_q);
        any_req     = |req;
        xfer_end    = done[grant_id_q] || !req[grant_id_q];
        timeout_hit = wd_expire && !xfer_end;
        err_set     = '0;
        if (timeout_hit) begin
            err_set = to_onehot(grant_id_q);
        end
    end

    // Arbiter FSM with registered grant/busy/abort outputs; abort defaults low
    // so it can only ever be a single-cycle pulse.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            abort_q    <= 1'b0;
            rr_ptr_q   <= IDW'(NUM_MASTERS - 1);
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q    <= GRANT;
                        grant_q    <= to_onehot(sel);
                        grant_id_q <= sel;
                        busy_q     <= 1'b1;
                        rr_ptr_q   <= sel;
                    end
                end
                GRANT: begin
                    if (xfer_end) begin
                        state_q <= RELEASE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q <= ABORT;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        abort_q <= 1'b1;
                    end
                end
                RELEASE: state_q <= IDLE;
                ABORT:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sticky error flags: a timeout set beats a clear of the same bit.
    always_comb begin
        err_d = (err_q & ~err_clr) | err_set;
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign abort    = abort_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bus_grant_watchdog.sv
// Directed bench for bus_grant_watchdog (NUM_MASTERS=2, TIMEOUT=100).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_bus_grant_watchdog;

    logic       clk = 1'b0;
    logic       rstN;
    logic [1:0] req;
    logic [1:0] done;
    logic       slave_ready;
    logic [1:0] err_clr;
    logic [1:0] grant;
    logic [0:0] grant_id;
    logic       busy;
    logic       abort;
    logic [1:0] err;

    int vecs = 0;
    int errs = 0;

    bus_grant_watchdog #(
        .NUM_MASTERS (2),
        .TIMEOUT     (100)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .req         (req),
        .done        (done),
        .slave_ready (slave_ready),
        .err_clr     (err_clr),
        .grant       (grant),
        .grant_id    (grant_id),
        .busy        (busy),
        .abort       (abort),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstN = 1'b0; req = '0; done = '0; err_clr = '0; slave_ready = 1'b0;
        #3;
        @(negedge clk);
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rstN = 1'b0; req = '0; done = '0; err_clr = '0; slave_ready = 1'b0;
        #3;
        vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL reset_grant: got %b expected 00", grant); end
        vecs++; if (grant_id !== 1'b0) begin errs++; $display("FAIL reset_grant_id: got %b expected 0", grant_id); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vecs++; if (abort !== 1'b0) begin errs++; $display("FAIL reset_abort: got %b expected 0", abort); end
        vecs++; if (err !== 2'b00) begin errs++; $display("FAIL reset_err: got %b expected 00", err); end
        @(negedge clk);
        rstN = 1'b1;
        tick();
        vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL idle_no_req_grant: got %b expected 00", grant); end
    endtask

    // Master 0 alone, ready every 10 cycles, done in cycle 30.
    task automatic test_single();
        logic abort_seen;
        abort_seen = 1'b0;
        req = 2'b01;
        for (int c = 1; c <= 31; c++) begin
            tick();
            if (abort === 1'b1) abort_seen = 1'b1;
            if (c == 1) begin
                vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL single_grant_c1: got %b expected 01", grant); end
                vecs++; if (grant_id !== 1'b0) begin errs++; $display("FAIL single_grant_id: got %b expected 0", grant_id); end
                vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy: got %b expected 1", busy); end
            end
            if (c == 30) begin
                vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL single_grant_c30: got %b expected 01", grant); end
            end
            if (c == 31) begin
                vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL single_grant_c31: got %b expected 00", grant); end
                vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL single_busy_c31: got %b expected 0", busy); end
            end
            slave_ready = (c % 10 == 0);
            done = (c == 30) ? 2'b01 : 2'b00;
        end
        vecs++; if (abort_seen !== 1'b0) begin errs++; $display("FAIL single_abort_seen: got %b expected 0", abort_seen); end
        vecs++; if (err !== 2'b00) begin errs++; $display("FAIL single_err: got %b expected 00", err); end
        req = '0; done = '0; slave_ready = 1'b0;
        tick(); tick();
    endtask

    // Both masters requesting, each finishing after 5 grant cycles.
    task automatic test_back_to_back();
        do_reset();
        slave_ready = 1'b1;
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            logic [1:0] exp;
            exp = (g % 2 == 1) ? 2'b10 : 2'b01;
            tick();
            vecs++; if (grant !== exp) begin errs++; $display("FAIL b2b_grant_%0d: got %b expected %b", g, grant, exp); end
            vecs++; if (grant_id !== 1'(g % 2)) begin errs++; $display("FAIL b2b_grant_id_%0d: got %b expected %0d", g, grant_id, g % 2); end
            for (int k = 2; k <= 5; k++) begin
                tick();
                if (k == 5) done = exp;
            end
            tick();
            done = '0;
            vecs++; if (grant !== 2'b00 || busy !== 1'b0) begin errs++; $display("FAIL b2b_gap1_%0d: got grant=%b busy=%b expected 00/0", g, grant, busy); end
            if (g == 3) req = '0;
            tick();
            vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL b2b_gap2_%0d: got %b expected 00", g, grant); end
        end
        slave_ready = 1'b0;
    endtask

    // Master 1 with no slave ready: abort 100 cycles after grant, err set wins over clear.
    task automatic test_timeout();
        logic ok;
        ok = 1'b1;
        slave_ready = 1'b0;
        req = 2'b10;
        tick();
        vecs++; if (grant !== 2'b10 || grant_id !== 1'b1) begin errs++; $display("FAIL to_grant: got %b/%b expected 10/1", grant, grant_id); end
        for (int t = 1; t <= 99; t++) begin
            tick();
            if (abort !== 1'b0 || grant !== 2'b10) ok = 1'b0;
            if (t == 99) err_clr = 2'b10;
        end
        vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL to_hold: got %b expected 1", ok); end
        tick();
        vecs++; if (abort !== 1'b1) begin errs++; $display("FAIL to_abort: got %b expected 1", abort); end
        vecs++; if (grant !== 2'b00 || busy !== 1'b0) begin errs++; $display("FAIL to_release: got grant=%b busy=%b expected 00/0", grant, busy); end
        vecs++; if (err !== 2'b10) begin errs++; $display("FAIL to_err_set_wins: got %b expected 10", err); end
        tick();
        err_clr = '0;
        vecs++; if (abort !== 1'b0) begin errs++; $display("FAIL to_abort_pulse: got %b expected 0", abort); end
        vecs++; if (err !== 2'b00) begin errs++; $display("FAIL to_err_clr: got %b expected 00", err); end
        tick();
        vecs++; if (grant !== 2'b10) begin errs++; $display("FAIL to_regrant: got %b expected 10", grant); end
        req = '0;
        tick(); tick();
    endtask

    // Ready in the terminal cycle rescues; count restarts and times out 100 cycles later.
    task automatic test_ready_at_timeout();
        logic ok;
        ok = 1'b1;
        slave_ready = 1'b0;
        req = 2'b01;
        tick();
        vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL rt_grant: got %b expected 01", grant); end
        for (int t = 1; t <= 99; t++) begin
            tick();
            if (t == 99) slave_ready = 1'b1;
        end
        tick();
        slave_ready = 1'b0;
        vecs++; if (abort !== 1'b0 || grant !== 2'b01) begin errs++; $display("FAIL rt_rescued: got abort=%b grant=%b expected 0/01", abort, grant); end
        for (int t = 101; t <= 199; t++) begin
            tick();
            if (abort !== 1'b0 || grant !== 2'b01) ok = 1'b0;
        end
        vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL rt_hold: got %b expected 1", ok); end
        tick();
        vecs++; if (abort !== 1'b1) begin errs++; $display("FAIL rt_abort: got %b expected 1", abort); end
        vecs++; if (err !== 2'b01) begin errs++; $display("FAIL rt_err: got %b expected 01", err); end
        req = '0;
        tick(); tick();
    endtask

    // Done coinciding with the timeout cycle releases without abort; foreign done ignored.
    task automatic test_done_at_timeout();
        slave_ready = 1'b0;
        req = 2'b10;
        tick();
        vecs++; if (grant !== 2'b10) begin errs++; $display("FAIL dt_grant: got %b expected 10", grant); end
        for (int t = 1; t <= 99; t++) begin
            tick();
            if (t == 50) done = 2'b01;
            if (t == 51) begin
                done = 2'b00;
                vecs++; if (grant !== 2'b10) begin errs++; $display("FAIL dt_foreign_done: got %b expected 10", grant); end
            end
            if (t == 99) done = 2'b10;
        end
        tick();
        done = '0;
        vecs++; if (grant !== 2'b00 || busy !== 1'b0) begin errs++; $display("FAIL dt_release: got grant=%b busy=%b expected 00/0", grant, busy); end
        vecs++; if (abort !== 1'b0) begin errs++; $display("FAIL dt_no_abort: got %b expected 0", abort); end
        vecs++; if (err !== 2'b01) begin errs++; $display("FAIL dt_err_unchanged: got %b expected 01", err); end
        req = '0;
        tick();
        vecs++; if (abort !== 1'b0) begin errs++; $display("FAIL dt_no_abort_late: got %b expected 0", abort); end
        err_clr = 2'b01;
        tick();
        err_clr = '0;
        vecs++; if (err !== 2'b00) begin errs++; $display("FAIL dt_err_clr: got %b expected 00", err); end
    endtask

    // Asynchronous reset in the middle of a grant.
    task automatic test_reset_mid();
        slave_ready = 1'b1;
        req = 2'b01;
        tick();
        vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL rm_grant: got %b expected 01", grant); end
        repeat (19) tick();
        #2 rstN = 1'b0;
        #1;
        vecs++; if (grant !== 2'b00 || busy !== 1'b0) begin errs++; $display("FAIL rm_async_drop: got grant=%b busy=%b expected 00/0", grant, busy); end
        vecs++; if (abort !== 1'b0) begin errs++; $display("FAIL rm_abort: got %b expected 0", abort); end
        @(negedge clk);
        rstN = 1'b1;
        tick();
        vecs++; if (grant !== 2'b01 || grant_id !== 1'b0) begin errs++; $display("FAIL rm_regrant: got %b/%b expected 01/0", grant, grant_id); end
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_ready_at_timeout();
        test_done_at_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: simulation did not complete");
        $fatal(1);
    end

endmodule
